// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: error tags and the buffered entry format.
package uart_pkg;

  localparam logic [1:0] UART_ERR_NONE = 2'b00;
  localparam logic [1:0] UART_ERR_FRM  = 2'b01;
  localparam logic [1:0] UART_ERR_PAR  = 2'b10;
  localparam logic [1:0] UART_ERR_OVR  = 2'b11;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } rx_entry_t;

  // An overrun is reported through the counter, never carried with a byte.
  function automatic logic [1:0] store_tag(input logic [1:0] ind);
    logic [1:0] tag;
    if (ind == UART_ERR_OVR) begin
      tag = UART_ERR_NONE;
    end else begin
      tag = ind;
    end
    return tag;
  endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// Tagged receive FIFO: DEPTH entries of {err, data}, show-ahead read, synchronous flush.
// Push and pop strobes arrive already qualified by the controller.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  rx_entry_t     i_wdata,
  output rx_entry_t     o_rdata,
  output logic [AW:0]   o_level,
  output logic          o_empty,
  output logic          o_full
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  rx_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;

  // Storage, pointers and occupancy; flush overrides any coincident push or pop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_FULL);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: edge-detected pushes from the RX FSM into a tagged FIFO,
// saturating error statistics, threshold and character-timeout interrupts.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             baud_clk_16x,
  input  logic             reset,
  input  logic             cfg_rx_enable,
  input  logic [AW:0]      cfg_rx_thr,
  input  logic [7:0]       cfg_timeout,
  input  logic             rx_flush,
  input  logic             fsm_fifo_wr,
  input  logic [7:0]       fsm_fifo_data,
  input  logic [1:0]       fsm_error_ind,
  output logic             fsm_fifo_aval,
  input  logic             rd_pop,
  output logic [7:0]       rd_data,
  output logic [1:0]       rd_err,
  output logic             rx_empty,
  output logic             rx_full,
  output logic [AW:0]      rx_level,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] ovr_err_cnt,
  output logic             intr_thr,
  output logic             intr_timeout
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != {CNT_W{1'b1}})) begin
      r = v + CNT_W'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic             r_wr_d;
  logic             r_ovr_d;
  logic [CNT_W-1:0] r_frm_cnt;
  logic [CNT_W-1:0] r_par_cnt;
  logic [CNT_W-1:0] r_ovr_cnt;
  logic [3:0]       r_presc;
  logic [7:0]       r_bitcnt;
  logic             r_intr_timeout;
  logic             r_intr_thr;

  logic             w_wr_rise;
  logic             w_ovr_rise;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [1:0]       w_tag;
  logic             w_restart;
  logic             w_tick;
  logic [7:0]       w_bit_nxt;
  rx_entry_t        w_wdata;
  rx_entry_t        w_rdata;
  logic [AW:0]      w_level;
  logic             w_empty;
  logic             w_full;

  assign w_wr_rise  = fsm_fifo_wr & ~r_wr_d;
  assign w_ovr_rise = (fsm_error_ind == UART_ERR_OVR) & cfg_rx_enable & ~fsm_fifo_wr & ~r_ovr_d;
  assign w_pop      = rd_pop & ~w_empty & ~rx_flush;
  assign w_push_req = w_wr_rise & cfg_rx_enable & ~rx_flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_tag      = store_tag(fsm_error_ind);
  assign w_wdata    = '{err: w_tag, data: fsm_fifo_data};

  uart_rx_buf #(.DEPTH(DEPTH)) u_buf (
    .i_clk   (baud_clk_16x),
    .i_reset (reset),
    .i_flush (rx_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Edge detectors for the byte strobe and the overrun indication.
  always_ff @(posedge baud_clk_16x) begin
    if (reset) begin
      r_wr_d  <= 1'b0;
      r_ovr_d <= 1'b0;
    end else begin
      r_wr_d  <= fsm_fifo_wr;
      r_ovr_d <= (fsm_error_ind == UART_ERR_OVR) & cfg_rx_enable & ~fsm_fifo_wr;
    end
  end

  // Saturating error statistics; clear takes precedence over any increment.
  always_ff @(posedge baud_clk_16x) begin
    if (reset || cnt_clr) begin
      r_frm_cnt <= '0;
      r_par_cnt <= '0;
      r_ovr_cnt <= '0;
    end else begin
      r_frm_cnt <= sat_inc(r_frm_cnt, w_push & (w_tag == UART_ERR_FRM));
      r_par_cnt <= sat_inc(r_par_cnt, w_push & (w_tag == UART_ERR_PAR));
      r_ovr_cnt <= sat_inc(r_ovr_cnt, w_drop | w_ovr_rise);
    end
  end

  assign w_restart = w_push | w_pop | rx_flush;
  assign w_tick    = (r_presc == 4'hF);
  assign w_bit_nxt = w_tick ? (r_bitcnt + 8'd1) : r_bitcnt;

  // Character timeout: the flag is set on the same edge the bit counter reaches the limit.
  always_ff @(posedge baud_clk_16x) begin
    if (reset || w_restart) begin
      r_presc        <= 4'd0;
      r_bitcnt       <= 8'd0;
      r_intr_timeout <= 1'b0;
    end else if (!w_empty && !r_intr_timeout) begin
      r_presc  <= r_presc + 4'd1;
      r_bitcnt <= w_bit_nxt;
      if (w_tick && (cfg_timeout != 8'd0) && (w_bit_nxt == cfg_timeout)) begin
        r_intr_timeout <= 1'b1;
      end
    end
  end

  // Threshold interrupt tracks the level one cycle behind.
  always_ff @(posedge baud_clk_16x) begin
    if (reset) begin
      r_intr_thr <= 1'b0;
    end else begin
      r_intr_thr <= (cfg_rx_thr != '0) && (w_level >= cfg_rx_thr);
    end
  end

  assign fsm_fifo_aval = cfg_rx_enable & ~w_full;
  assign rd_data       = w_rdata.data;
  assign rd_err        = w_rdata.err;
  assign rx_empty      = w_empty;
  assign rx_full       = w_full;
  assign rx_level      = w_level;
  assign frm_err_cnt   = r_frm_cnt;
  assign par_err_cnt   = r_par_cnt;
  assign ovr_err_cnt   = r_ovr_cnt;
  assign intr_thr      = r_intr_thr;
  assign intr_timeout  = r_intr_timeout;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX FSM. It accepts each byte and error code the FSM produces and buffers them in a small tagged FIFO. It gates the FSM through `fifo_aval`, keeps saturating error statistics, and raises threshold and character-timeout interrupts for the register block. It sits between `uart_rxfsm` and the UART register/interrupt logic and runs in the `baud_clk_16x` domain.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `CNT_W`, 8: error counter width.

- `baud_clk_16x`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_rx_enable`  in  1  receive enable.
- `cfg_rx_thr`  in  AW+1  threshold-interrupt level; 0 disables.
- `cfg_timeout`  in  8  character timeout in bit times (16 clocks each); 0 disables.
- `rx_flush`  in  1  synchronous FIFO flush pulse.
- `fsm_fifo_wr`  in  1  byte-complete strobe from RX FSM.
- `fsm_fifo_data`  in  8  received byte.
- `fsm_error_ind`  in  2  00 ok, 01 framing, 10 parity, 11 fifo-full.
- `fsm_fifo_aval`  out  1  space-available/enable to RX FSM.
- `rd_pop`  in  1  pop head entry.
- `rd_data`  out  8  head byte (show-ahead).
- `rd_err`  out  2  head error tag.
- `rx_empty`, `rx_full`  out  1  FIFO status.
- `rx_level`  out  AW+1  entries held.
- `cnt_clr`  in  1  clear all error counters.
- `frm_err_cnt`, `par_err_cnt`, `ovr_err_cnt`  out  CNT_W  saturating counts.
- `intr_thr`, `intr_timeout`  out  1  interrupt requests.

## Operation
- Push on rising edge of `fsm_fifo_wr` (registered `wr_d`; level high ≥1 cycle = one push). The push stores `{fsm_error_ind, fsm_fifo_data}` sampled in that cycle.
- `fsm_fifo_aval = cfg_rx_enable & ~rx_full`, combinational from registered state.
- Push when full: entry dropped, `ovr_err_cnt`+1.
- Overrun: `ovr_err_cnt`+1 on the rising edge of (`fsm_error_ind==11` & `cfg_rx_enable` & ~`fsm_fifo_wr`). The FSM holds 11 for the whole start bit, so only the edge is counted.
- Accepted push with tag 01: `frm_err_cnt`+1. Tag 10: `par_err_cnt`+1. Tag 11 is never stored; it is stored as 00.
- Counters saturate at all-ones. When `cnt_clr` and an increment coincide, `cnt_clr` wins and the result is 0.
- Pop when `rd_pop & ~rx_empty`. A pop when empty is ignored; pointers and `rd_data` are unchanged.
- Push and pop in the same cycle: both take effect and the level is unchanged. This holds when full too: the pop frees a slot and the push is accepted, no overrun.
- `rx_flush`: level←0, pointers←0, timeout state cleared. A coincident push or pop is discarded and not counted. Counters are unaffected.
- `cfg_rx_enable` low blocks new bytes only. The FIFO contents remain readable.
- Pointers are AW bits and wrap modulo DEPTH. The level counter is AW+1 bits.
- `intr_thr = (cfg_rx_thr!=0) & (rx_level >= cfg_rx_thr)`, registered.
- Timeout logic:
  - A 4-bit prescaler and an 8-bit bit-time counter run only while the FIFO is non-empty.
  - Both clear on any push, pop or flush.
  - When the counter equals `cfg_timeout` (≠0), `intr_timeout` is set sticky and counting stops.
  - `intr_timeout` clears on pop, push, flush or reset.

## Timing
- Reset values: `rx_empty`=1; `fsm_fifo_aval`=`cfg_rx_enable`. All other outputs, pointers, counters, prescaler and `wr_d` are 0. Reset mid-frame discards the FIFO and counters.
- Push latency: `fsm_fifo_wr` rises in cycle N → entry written at the edge ending N. `rx_empty`/`rx_level` update and `rd_data` is valid in N+1.
- Pop: `rd_pop` in cycle N → the next entry is on `rd_data` in N+1.
- `rx_full` rises in N+1 after the DEPTH-th push, so `fsm_fifo_aval` drops in N+1. The FSM checks it only at start-bit detection, at least 1 bit time later.
- Counter updates are visible the cycle after the event.
- `intr_thr` follows the level with 1 cycle lag.
- `intr_timeout` asserts 16·`cfg_timeout` + 1 cycles after the last push/pop while non-empty.

## Structure
- Package `uart_pkg`: localparams `UART_ERR_NONE`=2'b00, `UART_ERR_FRM`=2'b01, `UART_ERR_PAR`=2'b10, `UART_ERR_OVR`=2'b11.
- Sub-module `uart_rx_buf`: DEPTH×10-bit synchronous FIFO with pointers, level, full/empty and flush.
- `uart_rx_ctrl` holds the edge detection, counters, timeout and interrupts.

## Test plan
- Single byte: push 8'hA5 with tag 00 → one cycle later `rx_empty`=0, `rd_data`=A5, `rd_err`=00, `rx_level`=1. Pop → `rx_empty`=1.
- Fill and overflow (DEPTH=8):
  - 8 pushes → `rx_full`=1, `fsm_fifo_aval`=0.
  - 9th push → dropped, `ovr_err_cnt`=1.
  - Push+pop while full → level stays 8 and the new byte is read last.
- Errors: pushes tagged 01,01,10 → `frm_err_cnt`=2, `par_err_cnt`=1. `fsm_error_ind`=11 held 16 cycles → `ovr_err_cnt`+1 once. `cnt_clr` together with a 01 push → `frm_err_cnt`=0.
- Saturation: 300 framing-error pushes with pops → `frm_err_cnt`=8'hFF.
- Timeout: `cfg_timeout`=4, one push → `intr_timeout` rises exactly 65 cycles later and clears the cycle after a pop. With `cfg_timeout`=0 it never asserts.
- Threshold and flush: `cfg_rx_thr`=3 → `intr_thr` asserts after the 3rd push. `rx_flush` coincident with a push → level 0, `intr_thr`=0, counters unchanged.
